// File: rtl/ddr_fifo_sched_if.sv
// Start/length/address handshake between the burst scheduler and the AXI write/read engines.
// The master side is the scheduler; the slave side is the pair of engines.
interface ddr_fifo_sched_if #(
  parameter int unsigned ADDR_WIDTH      = 29,
  parameter int unsigned BURST_LEN_WIDTH = 8
);
  logic                       wr_start;
  logic [BURST_LEN_WIDTH-1:0] wr_burst_len;
  logic [ADDR_WIDTH-1:0]      wr_start_addr;
  logic                       wr_ready;
  logic                       wr_done;

  logic                       rd_start;
  logic [BURST_LEN_WIDTH-1:0] rd_burst_len;
  logic [ADDR_WIDTH-1:0]      rd_start_addr;
  logic                       rd_ready;
  logic                       rd_done;

  modport master (
    output wr_start, wr_burst_len, wr_start_addr,
    input  wr_ready, wr_done,
    output rd_start, rd_burst_len, rd_start_addr,
    input  rd_ready, rd_done
  );

  modport slave (
    input  wr_start, wr_burst_len, wr_start_addr,
    output wr_ready, wr_done,
    input  rd_start, rd_burst_len, rd_start_addr,
    output rd_ready, rd_done
  );
endinterface

// File: rtl/ddr_fifo_sched.sv
// Burst scheduler using a DDR region as a ring-buffer FIFO: one burst outstanding at a time,
// round-robin between write (stream in -> DDR) and read (DDR -> stream out) bursts.
module ddr_fifo_sched #(
  parameter int unsigned           ADDR_WIDTH      = 29,
  parameter int unsigned           BURST_LEN_WIDTH = 8,
  parameter int unsigned           BURST_LEN       = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int unsigned           DEPTH_LOG2      = 20,
  parameter int unsigned           CNT_WIDTH       = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enable,
  input  logic                  clr,
  input  logic [CNT_WIDTH-1:0]  wr_fifo_cnt,
  input  logic [CNT_WIDTH-1:0]  rd_fifo_space,
  ddr_fifo_sched_if.master      eng,
  output logic [DEPTH_LOG2:0]   ddr_fill,
  output logic                  ddr_empty,
  output logic                  ddr_full,
  output logic                  busy
);

  localparam logic [DEPTH_LOG2:0]   FillMax   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   BurstFill = (DEPTH_LOG2 + 1)'(BURST_LEN);
  localparam logic [DEPTH_LOG2-1:0] BurstPtr  = DEPTH_LOG2'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0]  BurstCnt  = CNT_WIDTH'(BURST_LEN);

  typedef enum logic [2:0] {StIdle, StWrIssue, StWrWait, StRdIssue, StRdWait} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic                  last_rd_q, last_rd_d;
  logic                  clr_pend_q, clr_pend_d;
  logic                  wr_start_c, rd_start_c;
  logic                  w_ok, r_ok;

  // Full-check written as fill <= max - burst so the sum can never overflow the fill width.
  assign w_ok = (wr_fifo_cnt >= BurstCnt) && (fill_q <= FillMax - BurstFill);
  assign r_ok = (rd_fifo_space >= BurstCnt) && (fill_q >= BurstFill);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    last_rd_d  = last_rd_q;
    clr_pend_d = clr_pend_q;
    wr_start_c = 1'b0;
    rd_start_c = 1'b0;

    if (clr && state_q != StIdle) clr_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (clr) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          fill_d   = '0;
        end else if (enable) begin
          // On a tie, last_rd_q picks write next, otherwise read.
          if (w_ok && (!r_ok || last_rd_q)) begin
            state_d   = StWrIssue;
            last_rd_d = 1'b0;
          end else if (r_ok) begin
            state_d   = StRdIssue;
            last_rd_d = 1'b1;
          end
        end
      end
      StWrIssue: begin
        wr_start_c = eng.wr_ready;
        if (eng.wr_ready) state_d = StWrWait;
      end
      StWrWait: begin
        if (eng.wr_done) begin
          state_d    = StIdle;
          clr_pend_d = 1'b0;
          if (clr_pend_q || clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + BurstPtr;
            fill_d   = fill_q + BurstFill;
          end
        end
      end
      StRdIssue: begin
        rd_start_c = eng.rd_ready;
        if (eng.rd_ready) state_d = StRdWait;
      end
      StRdWait: begin
        if (eng.rd_done) begin
          state_d    = StIdle;
          clr_pend_d = 1'b0;
          if (clr_pend_q || clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + BurstPtr;
            fill_d   = fill_q - BurstFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      last_rd_q  <= 1'b1;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      last_rd_q  <= last_rd_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // Pointers only move on done, so the addresses stay stable from issue through done.
  assign eng.wr_start_addr = BASE_ADDR + (ADDR_WIDTH'(wr_ptr_q) << 3);
  assign eng.rd_start_addr = BASE_ADDR + (ADDR_WIDTH'(rd_ptr_q) << 3);
  assign eng.wr_burst_len  = BURST_LEN_WIDTH'(BURST_LEN);
  assign eng.rd_burst_len  = BURST_LEN_WIDTH'(BURST_LEN);
  assign eng.wr_start      = wr_start_c;
  assign eng.rd_start      = rd_start_c;

  assign ddr_fill  = fill_q;
  assign ddr_empty = (fill_q == '0);
  assign ddr_full  = (fill_q == FillMax);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ddr_fifo_sched.sv
// Bench for ddr_fifo_sched on a 128-beat region: directed scenarios then randomized traffic,
// all checked against a transaction-level model of the scheduling rules.
module tb_ddr_fifo_sched;
  localparam int unsigned     AW    = 29;
  localparam int unsigned     BLW   = 8;
  localparam int unsigned     BL    = 64;
  localparam int unsigned     DL    = 7;
  localparam int unsigned     CW    = 11;
  localparam int              Depth = 128;
  localparam logic [AW-1:0]   BASE  = 29'h0010_0000;
  localparam logic [63:0]     BASE64 = 64'(BASE);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, clr;
  logic [CW-1:0] wr_fifo_cnt, rd_fifo_space;
  logic [DL:0]   ddr_fill;
  logic          ddr_empty, ddr_full, busy;

  always #5 clk = ~clk;

  ddr_fifo_sched_if #(.ADDR_WIDTH(AW), .BURST_LEN_WIDTH(BLW)) eng ();

  ddr_fifo_sched #(
    .ADDR_WIDTH(AW), .BURST_LEN_WIDTH(BLW), .BURST_LEN(BL), .BASE_ADDR(BASE),
    .DEPTH_LOG2(DL), .CNT_WIDTH(CW)
  ) u_dut (
    .ACLK(clk), .ARESETN(rst_n), .enable(enable), .clr(clr),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_space(rd_fifo_space), .eng(eng.master),
    .ddr_fill(ddr_fill), .ddr_empty(ddr_empty), .ddr_full(ddr_full), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  localparam int PIdle = 0, PWrIss = 1, PWrWait = 2, PRdIss = 3, PRdWait = 4;
  int m_phase, m_fill, m_wptr, m_rptr;
  bit m_last_rd, m_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PIdle; m_fill = 0; m_wptr = 0; m_rptr = 0; m_last_rd = 1'b1; m_pend = 1'b0;
  endtask

  task automatic model_clear();
    m_fill = 0; m_wptr = 0; m_rptr = 0;
  endtask

  function automatic logic [63:0] addr_of(input int p);
    return BASE64 + 64'(p * 8);
  endfunction

  task automatic compare_all();
    check("busy", 64'(busy), 64'(m_phase != PIdle));
    check("fill", 64'(ddr_fill), 64'(m_fill));
    check("empty", 64'(ddr_empty), 64'(m_fill == 0));
    check("full", 64'(ddr_full), 64'(m_fill == Depth));
    check("wr_addr", 64'(eng.wr_start_addr), addr_of(m_wptr));
    check("rd_addr", 64'(eng.rd_start_addr), addr_of(m_rptr));
    check("wr_start", 64'(eng.wr_start), 64'(m_phase == PWrIss && eng.wr_ready));
    check("rd_start", 64'(eng.rd_start), 64'(m_phase == PRdIss && eng.rd_ready));
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_edge();
    bit wok, rok, gw;
    if (m_phase != PIdle && clr) m_pend = 1'b1;
    case (m_phase)
      PIdle: begin
        if (clr) model_clear();
        else if (enable) begin
          wok = (int'(wr_fifo_cnt) >= BL) && (m_fill + BL <= Depth);
          rok = (int'(rd_fifo_space) >= BL) && (m_fill >= BL);
          gw  = (wok && rok) ? m_last_rd : wok;
          if (wok || rok) begin
            m_phase   = gw ? PWrIss : PRdIss;
            m_last_rd = !gw;
          end
        end
      end
      PWrIss: if (eng.wr_ready) m_phase = PWrWait;
      PRdIss: if (eng.rd_ready) m_phase = PRdWait;
      PWrWait: if (eng.wr_done) begin
        if (m_pend) model_clear();
        else begin m_wptr = (m_wptr + BL) % Depth; m_fill += BL; end
        m_pend = 1'b0; m_phase = PIdle;
      end
      PRdWait: if (eng.rd_done) begin
        if (m_pend) model_clear();
        else begin m_rptr = (m_rptr + BL) % Depth; m_fill -= BL; end
        m_pend = 1'b0; m_phase = PIdle;
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit en, input bit cl, input int cnt, input int sp,
                      input bit wrdy, input bit wdn, input bit rrdy, input bit rdn);
    @(negedge clk);
    enable = en; clr = cl;
    wr_fifo_cnt = CW'(cnt); rd_fifo_space = CW'(sp);
    eng.wr_ready = wrdy; eng.wr_done = wdn;
    eng.rd_ready = rrdy; eng.rd_done = rdn;
    #1;
    compare_all();
    model_edge();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_wr(input logic [63:0] exp_addr);
    step(1'b1, 1'b0, 64, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("do_wr_start", 64'(eng.wr_start), 64'd1);
    check("do_wr_addr", 64'(eng.wr_start_addr), exp_addr);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic do_rd(input logic [63:0] exp_addr);
    step(1'b1, 1'b0, 0, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("do_rd_start", 64'(eng.rd_start), 64'd1);
    check("do_rd_addr", 64'(eng.rd_start_addr), exp_addr);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; wr_fifo_cnt = '0; rd_fifo_space = '0;
    eng.wr_ready = 1'b0; eng.wr_done = 1'b0; eng.rd_ready = 1'b0; eng.rd_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    idle(1);
    check("rst_empty", 64'(ddr_empty), 64'd1);
    check("rst_full", 64'(ddr_full), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_addr", 64'(eng.wr_start_addr), BASE64);
    check("wr_len", 64'(eng.wr_burst_len), 64'd64);
    check("rd_len", 64'(eng.rd_burst_len), 64'd64);

    // First write, then tie resolved in favour of read
    do_wr(BASE64);
    check("t1_fill", 64'(ddr_fill), 64'd64);
    check("t1_next_addr", 64'(eng.wr_start_addr), BASE64 + 64'h200);
    step(1'b1, 1'b0, 64, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t2_rd_first", 64'(eng.rd_start), 64'd1);
    check("t2_no_wr", 64'(eng.wr_start), 64'd0);
    check("t2_rd_addr", 64'(eng.rd_start_addr), BASE64);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 64, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t2_fill", 64'(ddr_fill), 64'd0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t2_wr_next", 64'(eng.wr_start), 64'd1);
    check("t2_wr_addr", 64'(eng.wr_start_addr), BASE64 + 64'h200);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("t2_fill2", 64'(ddr_fill), 64'd64);

    // clr in idle
    step(1'b1, 1'b1, 64, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("clr_idle_fill", 64'(ddr_fill), 64'd0);
    check("clr_idle_busy", 64'(busy), 64'd0);
    check("clr_idle_rd_addr", 64'(eng.rd_start_addr), BASE64);

    // Fill to full, writes blocked, wrap after a read
    do_wr(BASE64);
    do_wr(BASE64 + 64'h200);
    check("t3_full", 64'(ddr_full), 64'd1);
    check("t3_fill", 64'(ddr_fill), 64'd128);
    repeat (4) step(1'b1, 1'b0, 64, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_blocked", 64'(busy), 64'd0);
    do_rd(BASE64);
    do_wr(BASE64);
    check("t3_full_again", 64'(ddr_full), 64'd1);

    // clr during read wait
    step(1'b1, 1'b0, 0, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_rd_start", 64'(eng.rd_start), 64'd1);
    check("t5_rd_addr", 64'(eng.rd_start_addr), BASE64 + 64'h200);
    step(1'b1, 1'b1, 0, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_still_busy", 64'(busy), 64'd1);
    step(1'b1, 1'b0, 0, 64, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 0, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_fill", 64'(ddr_fill), 64'd0);
    check("t5_empty", 64'(ddr_empty), 64'd1);
    check("t5_wr_addr", 64'(eng.wr_start_addr), BASE64);
    repeat (4) begin
      step(1'b1, 1'b0, 0, 64, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t5_no_rd", 64'(eng.rd_start), 64'd0);
    end

    // wr_ready withheld in issue
    step(1'b1, 1'b0, 64, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) begin
      step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t4_held", 64'(eng.wr_start), 64'd0);
    end
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_pulse", 64'(eng.wr_start), 64'd1);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_one_cycle", 64'(eng.wr_start), 64'd0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("t4_fill", 64'(ddr_fill), 64'd64);

    // enable low blocks grants
    repeat (3) step(1'b0, 1'b0, 64, 64, 1'b1, 1'b0, 1'b1, 1'b0);
    check("en_blocked", 64'(busy), 64'd0);

    // Asynchronous reset during write wait
    step(1'b1, 1'b0, 64, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_fill", 64'(ddr_fill), 64'd0);
    check("arst_empty", 64'(ddr_empty), 64'd1);
    check("arst_wr_addr", 64'(eng.wr_start_addr), BASE64);
    check("arst_rd_addr", 64'(eng.rd_start_addr), BASE64);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("arst_spurious_done", 64'(ddr_fill), 64'd0);

    // Randomized traffic, including spurious dones, clr pulses and enable drops
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
           int'($urandom_range(0, 130)), int'($urandom_range(0, 130)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
